hex_capture: RTL and testbench

HEX_CAPTURE -- requirements
Module: hex_capture

---
 rtl/hex_capture_pkg.sv | 57 +++++
 rtl/hex_capture_seg_decode.sv | 28 ++
 rtl/hex_capture.sv | 184 ++++++++++++++++++
 tb/tb_hex_capture.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_capture_pkg.sv
// +--------------------------------------------------------------------+
// | hex_capture_pkg : glyph table, sampler states, enable-bus helpers   |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

package hex_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Active-low segment patterns (bit6=g .. bit0=a); element k is the glyph for nibble k.
    localparam logic [15:0][6:0] SEG_GLYPHS = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    function automatic logic [3:0] count_low(input logic [7:0] en_n);
        logic [3:0] n;
        n = '0;
        for (int k = 0; k < 8; k++) begin
            n = n + {3'b000, ~en_n[k]};
        end
        return n;
    endfunction

    function automatic logic [2:0] low_index(input logic [7:0] en_n);
        logic [2:0] idx;
        idx = '0;
        for (int k = 7; k >= 0; k--) begin
            if (!en_n[k]) begin
                idx = 3'(k);
            end
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hex_capture_seg_decode.sv
// +--------------------------------------------------------------------+
// | seg_decode : combinational 7-segment pattern to nibble lookup       |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

module seg_decode
    import hex_capture_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       hit
);

    always_comb begin
        nibble = '0;
        hit    = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (seg == SEG_GLYPHS[k]) begin
                nibble = 4'(k);
                hit    = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/hex_capture.sv
// +--------------------------------------------------------------------+
// | hex_capture : captures multiplexed 7-segment digits into nibbles    |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

module hex_capture
    import hex_capture_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  hex,
    input  logic [7:0]  hex_on,
    output logic [31:0] digits,
    output logic [7:0]  digit_valid,
    output logic [7:0]  digit_err,
    output logic        upd,
    output logic [2:0]  upd_idx,
    output logic        collision
);

    localparam logic [7:0]  STABLE_TARGET = 8'(STABLE_CYCLES);
    localparam logic [23:0] AGE_LIMIT     = 24'(TIMEOUT);

    logic [6:0] hex_meta, hex_sync, hex_prev;
    logic [7:0] on_meta, on_sync, on_prev;
    logic       multi_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hex_meta <= 7'h7F;
            hex_sync <= 7'h7F;
            hex_prev <= 7'h7F;
            on_meta  <= 8'hFF;
            on_sync  <= 8'hFF;
            on_prev  <= 8'hFF;
        end else begin
            hex_meta <= hex;
            hex_sync <= hex_meta;
            hex_prev <= hex_sync;
            on_meta  <= hex_on;
            on_sync  <= on_meta;
            on_prev  <= on_sync;
        end
    end

    logic [3:0] low_cnt;
    logic       one_low;
    logic       multi_low;
    logic       changed;
    logic [2:0] cap_idx;

    assign low_cnt   = count_low(on_sync);
    assign one_low   = (low_cnt == 4'd1);
    assign multi_low = (low_cnt >= 4'd2);
    assign changed   = (hex_sync != hex_prev) || (on_sync != on_prev);
    assign cap_idx   = low_index(on_sync);

    state_t     state, state_next;
    logic [7:0] stab_cnt, stab_next;
    logic       capture;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            stab_cnt <= '0;
        end else begin
            state    <= state_next;
            stab_cnt <= stab_next;
        end
    end

    always_comb begin
        state_next = state;
        stab_next  = stab_cnt;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (one_low) begin
                    state_next = ST_COUNT;
                    stab_next  = 8'd1;
                end
            end
            ST_COUNT: begin
                if (changed) begin
                    if (one_low) begin
                        stab_next = 8'd1;
                    end else begin
                        state_next = ST_IDLE;
                        stab_next  = '0;
                    end
                end else begin
                    stab_next = stab_cnt + 8'd1;
                    if (stab_next == STABLE_TARGET) begin
                        capture    = 1'b1;
                        state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (changed) begin
                    if (one_low) begin
                        state_next = ST_COUNT;
                        stab_next  = 8'd1;
                    end else begin
                        state_next = ST_IDLE;
                        stab_next  = '0;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                stab_next  = '0;
            end
        endcase
    end

    logic [3:0] dec_nibble;
    logic       dec_hit;

    seg_decode u_seg_decode (
        .seg    (hex_sync),
        .nibble (dec_nibble),
        .hit    (dec_hit)
    );

    // timeout_hit fires once, on the cycle the age counter steps onto AGE_LIMIT.
    logic [7:0] timeout_hit;

    for (genvar g = 0; g < 8; g++) begin : g_age
        logic [23:0] age;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                age <= '0;
            end else if (capture && (cap_idx == 3'(g))) begin
                age <= '0;
            end else if (age != AGE_LIMIT) begin
                age <= age + 24'd1;
            end
        end

        assign timeout_hit[g] = (age == AGE_LIMIT - 24'd1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digits      <= '0;
            digit_valid <= '0;
            digit_err   <= '0;
            upd         <= 1'b0;
            upd_idx     <= '0;
            collision   <= 1'b0;
            multi_prev  <= 1'b0;
        end else begin
            upd        <= capture;
            collision  <= multi_low && !multi_prev;
            multi_prev <= multi_low;
            for (int k = 0; k < 8; k++) begin
                if (timeout_hit[k]) begin
                    digit_valid[k] <= 1'b0;
                end
            end
            // Placed after the timeout loop so a same-cycle capture overrides it.
            if (capture) begin
                upd_idx <= cap_idx;
                if (dec_hit) begin
                    digits[{cap_idx, 2'b00} +: 4] <= dec_nibble;
                    digit_valid[cap_idx]          <= 1'b1;
                    digit_err[cap_idx]            <= 1'b0;
                end else begin
                    digit_valid[cap_idx] <= 1'b0;
                    digit_err[cap_idx]   <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hex_capture.sv
// +--------------------------------------------------------------------+
// | tb_hex_capture : scoreboard bench for hex_capture                   |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_hex_capture;

    localparam int STABLE = 4;
    localparam int TMO    = 100;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic [6:0]  hex    = 7'h7F;
    logic [7:0]  hex_on = 8'hFF;
    logic [31:0] digits;
    logic [7:0]  digit_valid;
    logic [7:0]  digit_err;
    logic        upd;
    logic [2:0]  upd_idx;
    logic        collision;

    hex_capture #(
        .STABLE_CYCLES (STABLE),
        .TIMEOUT       (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hex         (hex),
        .hex_on      (hex_on),
        .digits      (digits),
        .digit_valid (digit_valid),
        .digit_err   (digit_err),
        .upd         (upd),
        .upd_idx     (upd_idx),
        .collision   (collision)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] idx;
        logic [3:0] nib;
        logic       v;
        logic       e;
    } ev_t;

    ev_t         exp_q[$];
    ev_t         obs_q[$];
    ev_t         e_ev, o_ev;
    int          n_cmp    = 0;
    int          n_bad    = 0;
    int          coll_cnt = 0;
    logic [6:0]  glyph [16];
    logic [31:0] m_digits = '0;

    // Inputs change only right after a falling-edge sample.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (upd) begin
                obs_q.push_back({upd_idx, digits[{upd_idx, 2'b00} +: 4],
                                 digit_valid[upd_idx], digit_err[upd_idx]});
            end
            if (collision) coll_cnt++;
        end
    endtask

    task automatic expect_hit(input int idx, input logic [3:0] nib);
        m_digits[idx*4 +: 4] = nib;
        exp_q.push_back({3'(idx), nib, 1'b1, 1'b0});
    endtask

    task automatic expect_miss(input int idx);
        exp_q.push_back({3'(idx), m_digits[idx*4 +: 4], 1'b0, 1'b1});
    endtask

    task automatic blank(input int n);
        hex_on = 8'hFF;
        hex    = 7'h7F;
        tick(n);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(3);
        n_cmp++; if (digits !== 32'h0) begin n_bad++; $display("FAIL reset_digits: got %h want 0", digits); end
        n_cmp++; if (digit_valid !== 8'h0) begin n_bad++; $display("FAIL reset_valid: got %h want 0", digit_valid); end
        n_cmp++; if (digit_err !== 8'h0) begin n_bad++; $display("FAIL reset_err: got %h want 0", digit_err); end
        n_cmp++; if (upd !== 1'b0) begin n_bad++; $display("FAIL reset_upd: got %b want 0", upd); end
        n_cmp++; if (upd_idx !== 3'd0) begin n_bad++; $display("FAIL reset_upd_idx: got %0d want 0", upd_idx); end
        n_cmp++; if (collision !== 1'b0) begin n_bad++; $display("FAIL reset_collision: got %b want 0", collision); end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_single_capture;
        hex_on = 8'hFE;
        hex    = 7'b0100100;
        expect_hit(0, 4'h2);
        tick(10);
        while (exp_q.size() > 0) begin
            e_ev = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL single_upd: got none want %h", e_ev); end
            else begin
                o_ev = obs_q.pop_front();
                if (o_ev !== e_ev) begin n_bad++; $display("FAIL single_upd: got %h want %h", o_ev, e_ev); end
            end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL single_extra_upd: got %0d extra want 0", obs_q.size()); obs_q.delete(); end
        n_cmp++; if (digit_valid !== 8'h01) begin n_bad++; $display("FAIL single_valid: got %h want 01", digit_valid); end
        n_cmp++; if (digits[3:0] !== 4'h2) begin n_bad++; $display("FAIL single_digit0: got %h want 2", digits[3:0]); end
        blank(3);
    endtask

    task automatic test_illegal_glyph;
        hex_on = 8'h7F;
        hex    = 7'b0001110;
        tick(3);
        hex    = 7'b1111111;
        tick(4);
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL short_hold_upd: got %0d upd want 0", obs_q.size()); obs_q.delete(); end
        expect_miss(7);
        tick(6);
        while (exp_q.size() > 0) begin
            e_ev = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL miss_upd: got none want %h", e_ev); end
            else begin
                o_ev = obs_q.pop_front();
                if (o_ev !== e_ev) begin n_bad++; $display("FAIL miss_upd: got %h want %h", o_ev, e_ev); end
            end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL miss_extra_upd: got %0d extra want 0", obs_q.size()); obs_q.delete(); end
        n_cmp++; if (digit_err[7] !== 1'b1) begin n_bad++; $display("FAIL miss_err7: got %b want 1", digit_err[7]); end
        n_cmp++; if (digit_valid[7] !== 1'b0) begin n_bad++; $display("FAIL miss_valid7: got %b want 0", digit_valid[7]); end
        blank(3);
    endtask

    task automatic test_collision;
        coll_cnt = 0;
        hex    = 7'b0010010;
        hex_on = 8'hFC;
        tick(8);
        n_cmp++; if (coll_cnt != 1) begin n_bad++; $display("FAIL collision_pulses: got %0d want 1", coll_cnt); end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL collision_upd: got %0d upd want 0", obs_q.size()); obs_q.delete(); end
        hex_on = 8'hFD;
        expect_hit(1, 4'h5);
        tick(8);
        while (exp_q.size() > 0) begin
            e_ev = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL after_collision_upd: got none want %h", e_ev); end
            else begin
                o_ev = obs_q.pop_front();
                if (o_ev !== e_ev) begin n_bad++; $display("FAIL after_collision_upd: got %h want %h", o_ev, e_ev); end
            end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL after_collision_extra: got %0d extra want 0", obs_q.size()); obs_q.delete(); end
        n_cmp++; if (coll_cnt != 1) begin n_bad++; $display("FAIL collision_repeat: got %0d want 1", coll_cnt); end
        blank(3);
    endtask

    task automatic test_timeout;
        int waited;
        hex_on = 8'hF7;
        hex    = 7'b0010000;
        expect_hit(3, 4'h9);
        waited = 0;
        while (obs_q.size() == 0 && waited < 20) begin
            tick(1);
            waited++;
        end
        while (exp_q.size() > 0) begin
            e_ev = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL timeout_capture: got none want %h", e_ev); end
            else begin
                o_ev = obs_q.pop_front();
                if (o_ev !== e_ev) begin n_bad++; $display("FAIL timeout_capture: got %h want %h", o_ev, e_ev); end
            end
        end
        hex_on = 8'hFF;
        hex    = 7'h7F;
        waited = 0;
        while (digit_valid[3] === 1'b1 && waited < 200) begin
            tick(1);
            waited++;
        end
        n_cmp++; if (waited != TMO) begin n_bad++; $display("FAIL timeout_cycles: got %0d want %0d", waited, TMO); end
        n_cmp++; if (digits[15:12] !== 4'h9) begin n_bad++; $display("FAIL timeout_digit3: got %h want 9", digits[15:12]); end
        n_cmp++; if (digit_err[3] !== 1'b0) begin n_bad++; $display("FAIL timeout_err3: got %b want 0", digit_err[3]); end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL timeout_extra_upd: got %0d extra want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_reset_abort;
        hex_on = 8'hFB;
        hex    = 7'b0011001;
        tick(5);
        rst_n = 1'b0;
        tick(1);
        m_digits = '0;
        n_cmp++; if (digits !== 32'h0) begin n_bad++; $display("FAIL abort_digits: got %h want 0", digits); end
        n_cmp++; if (digit_valid !== 8'h0) begin n_bad++; $display("FAIL abort_valid: got %h want 0", digit_valid); end
        n_cmp++; if (digit_err !== 8'h0) begin n_bad++; $display("FAIL abort_err: got %h want 0", digit_err); end
        n_cmp++; if (upd !== 1'b0 || upd_idx !== 3'd0) begin n_bad++; $display("FAIL abort_upd: got %b/%0d want 0/0", upd, upd_idx); end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL abort_pending_upd: got %0d upd want 0", obs_q.size()); obs_q.delete(); end
        rst_n = 1'b1;
        tick(5);
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL abort_early_upd: got %0d upd want 0", obs_q.size()); obs_q.delete(); end
        expect_hit(2, 4'h4);
        tick(4);
        while (exp_q.size() > 0) begin
            e_ev = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL abort_recapture: got none want %h", e_ev); end
            else begin
                o_ev = obs_q.pop_front();
                if (o_ev !== e_ev) begin n_bad++; $display("FAIL abort_recapture: got %h want %h", o_ev, e_ev); end
            end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL abort_extra_upd: got %0d extra want 0", obs_q.size()); obs_q.delete(); end
        blank(3);
    endtask

    task automatic test_scan;
        coll_cnt = 0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) begin
                hex_on = ~(8'd1 << i);
                hex    = glyph[i];
                expect_hit(i, 4'(i));
                tick(8);
            end
        end
        tick(6);
        while (exp_q.size() > 0) begin
            e_ev = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL scan_upd: got none want %h", e_ev); end
            else begin
                o_ev = obs_q.pop_front();
                if (o_ev !== e_ev) begin n_bad++; $display("FAIL scan_upd: got %h want %h", o_ev, e_ev); end
            end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL scan_extra_upd: got %0d extra want 0", obs_q.size()); obs_q.delete(); end
        n_cmp++; if (digits !== 32'h76543210) begin n_bad++; $display("FAIL scan_digits: got %h want 76543210", digits); end
        n_cmp++; if (digit_valid !== 8'hFF) begin n_bad++; $display("FAIL scan_valid: got %h want ff", digit_valid); end
        n_cmp++; if (digit_err !== 8'h00) begin n_bad++; $display("FAIL scan_err: got %h want 00", digit_err); end
        n_cmp++; if (coll_cnt != 0) begin n_bad++; $display("FAIL scan_collision: got %0d want 0", coll_cnt); end
    endtask

    initial begin
        glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001; glyph[2]  = 7'b0100100; glyph[3]  = 7'b0110000;
        glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010; glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000;
        glyph[8]  = 7'b0000000; glyph[9]  = 7'b0010000; glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
        glyph[12] = 7'b1000110; glyph[13] = 7'b0100001; glyph[14] = 7'b0000110; glyph[15] = 7'b0001110;

        test_reset();
        test_single_capture();
        test_illegal_glyph();
        test_collision();
        test_timeout();
        test_reset_abort();
        test_scan();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
